// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer
// Receive-side sequencer for a UART shift-register datapath. It synchronises
// the serial line, qualifies start bits at mid-bit, and times every bit with
// its own baud counter. It emits one RShift strobe at the centre of each data
// bit, then reports Byte_Done or Frame_Err at the centre of the stop bit.
//
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit, and a Parity_Err output pulse.
//
// The pulse outputs are decoded from registered state only: the state, the
// baud counter, the bit counter and the synchronised line flop. They settle
// right after the clock edge and carry no input-to-output combinational path.
`timescale 1ns/1ps

module uart_rx_sequencer #(
  parameter int CLKS_PER_BIT = 21700,
  parameter int DATA_BITS    = 8
) (
  input  logic CLOCK_50,
  input  logic Reset_n,
  input  logic Rx,
  output logic Rx_Bit,
  output logic RShift,
  output logic Byte_Done,
  output logic Frame_Err,
`ifdef UART_RX_PARITY_EN
  output logic Parity_Err,
`endif
  output logic Busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  // Terminal counts: a full bit period, and half a period for start qualification
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Synchroniser flops: the line idles high, so both flops reset to 1
  logic sync_meta_r;
  logic sync_line_r;

  // Sequencer registers and their next-state values
  state_t            state_r;
  state_t            state_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [BAUD_W-1:0] baud_cnt_s;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_s;

  // Output decodes
  logic rshift_s;
  logic byte_done_s;
  logic frame_err_s;

`ifdef UART_RX_PARITY_EN
  // Running even-parity accumulator and the verdict taken at the parity bit
  logic par_acc_r;
  logic par_acc_s;
  logic par_bad_r;
  logic par_bad_s;
  logic parity_err_s;

  // One step of the running XOR over the received bits
  function automatic logic par_step(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction
`endif

  // Two-flop synchroniser; everything downstream looks only at sync_line_r
  always_ff @(posedge CLOCK_50) begin
    if (!Reset_n) begin
      sync_meta_r <= 1'b1;
      sync_line_r <= 1'b1;
    end else begin
      sync_meta_r <= Rx;
      sync_line_r <= sync_meta_r;
    end
  end

  // State and counter registers, cleared by the synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (!Reset_n) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= BIT_ZERO;
    end else begin
      state_r    <= state_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity registers, cleared by the synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (!Reset_n) begin
      par_acc_r <= 1'b0;
      par_bad_r <= 1'b0;
    end else begin
      par_acc_r <= par_acc_s;
      par_bad_r <= par_bad_s;
    end
  end
`endif

  // Next-state, counter and strobe decode; the baud counter restarts on every state entry
  always_comb begin
    state_s     = state_r;
    baud_cnt_s  = baud_cnt_r + BAUD_ONE;
    bit_cnt_s   = bit_cnt_r;
    rshift_s    = 1'b0;
    byte_done_s = 1'b0;
    frame_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_acc_s    = par_acc_r;
    par_bad_s    = par_bad_r;
    parity_err_s = 1'b0;
`endif

    case (state_r)
      ST_IDLE: begin
        baud_cnt_s = BAUD_ZERO;
        if (!sync_line_r) begin
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_START: begin
        // Re-check the line half a bit later; a short low pulse is a glitch
        if (baud_cnt_r == HALF_LAST) begin
          baud_cnt_s = BAUD_ZERO;
          bit_cnt_s  = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
          par_acc_s  = 1'b0;
          par_bad_s  = 1'b0;
`endif
          if (!sync_line_r) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_START;
        end
      end

      ST_DATA: begin
        // Counting starts at a bit centre, so every terminal count lands on a centre
        if (baud_cnt_r == BAUD_LAST) begin
          rshift_s   = 1'b1;
          baud_cnt_s = BAUD_ZERO;
          bit_cnt_s  = bit_cnt_r + BIT_ONE;
`ifdef UART_RX_PARITY_EN
          par_acc_s  = par_step(par_acc_r, sync_line_r);
`endif
          if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_STOP;
`endif
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        // Even parity: data bits XOR parity bit must come to zero
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_s = BAUD_ZERO;
          par_bad_s  = par_step(par_acc_r, sync_line_r);
          state_s    = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif

      ST_STOP: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_cnt_s = BAUD_ZERO;
          if (sync_line_r) begin
`ifdef UART_RX_PARITY_EN
            byte_done_s  = !par_bad_r;
            parity_err_s = par_bad_r;
`else
            byte_done_s  = 1'b1;
`endif
            state_s = ST_IDLE;
          end else begin
            // A framing error overrides any parity verdict
            frame_err_s = 1'b1;
            state_s     = ST_BREAK;
          end
        end else begin
          state_s = ST_STOP;
        end
      end

      ST_BREAK: begin
        // Hold here until the line recovers so a stuck-low line reports once
        baud_cnt_s = BAUD_ZERO;
        if (sync_line_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        baud_cnt_s = BAUD_ZERO;
        bit_cnt_s  = BIT_ZERO;
      end
    endcase
  end

  assign Rx_Bit     = sync_line_r;
  assign RShift     = rshift_s;
  assign Byte_Done  = byte_done_s;
  assign Frame_Err  = frame_err_s;
  assign Busy       = (state_r != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign Parity_Err = parity_err_s;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer at CLKS_PER_BIT = 16, DATA_BITS = 8.
// A negedge monitor tallies strobes and captures Rx_Bit at each RShift.
// A single initial block drives frames and checks expected counts and bytes.
`timescale 1ns/1ps

module tb_uart_rx_sequencer;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic Reset_n  = 1'b0;
  logic Rx       = 1'b1;
  logic Rx_Bit;
  logic RShift;
  logic Byte_Done;
  logic Frame_Err;
  logic Busy;
  logic perr_s;
`ifdef UART_RX_PARITY_EN
  logic Parity_Err;
  assign perr_s = Parity_Err;
`else
  assign perr_s = 1'b0;
`endif

  uart_rx_sequencer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .Reset_n   (Reset_n),
    .Rx        (Rx),
    .Rx_Bit    (Rx_Bit),
    .RShift    (RShift),
    .Byte_Done (Byte_Done),
    .Frame_Err (Frame_Err),
`ifdef UART_RX_PARITY_EN
    .Parity_Err(Parity_Err),
`endif
    .Busy      (Busy)
  );

  // 50 MHz clock
  always #10 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;

  // Cycle counter: value k right after the k-th rising edge
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge
  int n_rs = 0, n_done = 0, n_ferr = 0, n_perr = 0, n_viol = 0;
  int rs_cyc[$];
  int done_byte[$];
  int done_busy[$];
  int busy_runs[$];
  logic [7:0] cap = 8'h00;
  logic prev_done = 1'b0;
  int busy_run = 0;

  always @(negedge CLOCK_50) begin
    if (RShift === 1'b1) begin
      n_rs <= n_rs + 1;
      rs_cyc.push_back(cyc);
      cap <= {Rx_Bit, cap[7:1]};
    end
    if (Byte_Done === 1'b1) begin
      n_done <= n_done + 1;
      done_byte.push_back(int'(cap));
    end
    if (Frame_Err === 1'b1) n_ferr <= n_ferr + 1;
    if (perr_s === 1'b1) n_perr <= n_perr + 1;
    if ((((Byte_Done | Frame_Err | perr_s) & RShift) | (Byte_Done & Frame_Err) |
         (Byte_Done & perr_s) | (Frame_Err & perr_s)) === 1'b1)
      n_viol <= n_viol + 1;
    if (prev_done) done_busy.push_back(int'(Busy));
    prev_done <= (Byte_Done === 1'b1);
    if (Busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else begin
      if (busy_run != 0) busy_runs.push_back(busy_run);
      busy_run <= 0;
    end
  end

  // Watchdog: the whole run is a few thousand cycles
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
    #1;
  endtask

  task automatic align();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_bit(input logic v);
    Rx = v;
    repeat (CPB) @(posedge CLOCK_50);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, optional parity bit, stop bit
  task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (PAR_EN) send_bit(par_bit);
    send_bit(stop_bit);
  endtask

  function automatic int byte_at(input int idx);
    return (done_byte.size() > idx) ? done_byte[idx] : -1;
  endfunction

  int b_rs, b_done, b_ferr, b_perr, fall_cyc, bad, lat, frun;
  logic found;

  initial begin
    // Reset state
    Reset_n = 1'b0;
    Rx = 1'b1;
    wait_cycles(3);
    check("rst_rx_bit", Rx_Bit, 1);
    check("rst_busy", Busy, 0);
    check("rst_rshift", RShift, 0);
    check("rst_byte_done", Byte_Done, 0);
    check("rst_frame_err", Frame_Err, 0);
    Reset_n = 1'b1;
    wait_cycles(5);

    // Frame 0xA5
    b_rs = n_rs; b_done = n_done; b_ferr = n_ferr;
    align();
    fall_cyc = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_cycles(20);
    check("a5_rshift_count", n_rs - b_rs, 8);
    lat = (rs_cyc.size() > b_rs) ? (rs_cyc[b_rs] - fall_cyc) : -1;
    check_range("a5_first_rshift_latency", lat, 25, 27);
    bad = 0;
    if (rs_cyc.size() >= b_rs + 8) begin
      for (int i = 1; i < 8; i++)
        if (rs_cyc[b_rs + i] - rs_cyc[b_rs + i - 1] != CPB) bad++;
    end else begin
      bad = 99;
    end
    check("a5_rshift_spacing_bad", bad, 0);
    check("a5_byte", byte_at(b_done), 32'hA5);
    check("a5_byte_done_count", n_done - b_done, 1);
    check("a5_frame_err_count", n_ferr - b_ferr, 0);
    check("a5_busy_after_done", (done_busy.size() > b_done) ? done_busy[b_done] : -1, 0);

    // False start: 4-cycle low pulse
    b_rs = n_rs; b_done = n_done; frun = busy_runs.size();
    align();
    Rx = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
    Rx = 1'b1;
    wait_cycles(30);
    check("false_rshift_count", n_rs - b_rs, 0);
    check("false_byte_done_count", n_done - b_done, 0);
    check_range("false_busy_run", (busy_runs.size() > frun) ? busy_runs[frun] : -1, 1, 10);
    check("false_busy_idle", Busy, 0);

    // Low stop bit, then line held low for 100 cycles
    b_done = n_done; b_ferr = n_ferr;
    align();
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (100) @(posedge CLOCK_50);
    #1;
    check("brk_busy_held", Busy, 1);
    check("brk_frame_err_count", n_ferr - b_ferr, 1);
    check("brk_byte_done_count", n_done - b_done, 0);
    Rx = 1'b1;
    wait_cycles(10);
    check("brk_busy_released", Busy, 0);
    b_rs = n_rs; b_done = n_done;
    align();
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_cycles(20);
    check("brk_next_byte", byte_at(b_done), 32'h3C);
    check("brk_next_done_count", n_done - b_done, 1);
    check("brk_total_frame_err", n_ferr - b_ferr, 1);

    // Reset after the 3rd RShift of a frame
    b_rs = n_rs; b_done = n_done;
    align();
    fork
      send_frame(8'hFC, 1'b0, 1'b1);
      begin
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge CLOCK_50);
          #1;
          if (n_rs - b_rs >= 3) found = 1'b1;
        end
        check("rst_mid_third_rshift_seen", found, 1);
        if (found) begin
          Reset_n = 1'b0;
          @(negedge CLOCK_50);
          #1;
          Reset_n = 1'b1;
          check("rst_mid_busy", Busy, 0);
          check("rst_mid_rshift", RShift, 0);
        end
      end
    join
    wait_cycles(20);
    check("rst_mid_rshift_count", n_rs - b_rs, 3);
    check("rst_mid_byte_done_count", n_done - b_done, 0);
    b_rs = n_rs; b_done = n_done;
    align();
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_cycles(20);
    check("rst_fresh_rshift_count", n_rs - b_rs, 8);
    check("rst_fresh_done_count", n_done - b_done, 1);
    check("rst_fresh_byte", byte_at(b_done), 32'hFF);

    // Back-to-back frames with no idle gap
    b_rs = n_rs; b_done = n_done; b_ferr = n_ferr; b_perr = n_perr;
    align();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_cycles(20);
    check("b2b_rshift_count", n_rs - b_rs, 16);
    check("b2b_done_count", n_done - b_done, 2);
    check("b2b_byte0", byte_at(b_done), 32'h00);
    check("b2b_byte1", byte_at(b_done + 1), 32'hFF);
    check("b2b_frame_err_count", n_ferr - b_ferr, 0);
    check("b2b_parity_err_count", n_perr - b_perr, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    b_done = n_done; b_perr = n_perr;
    align();
    send_frame(8'h07, 1'b0, 1'b1);
    wait_cycles(20);
    check("par_bad_perr_count", n_perr - b_perr, 1);
    check("par_bad_done_count", n_done - b_done, 0);
    b_done = n_done; b_perr = n_perr;
    align();
    send_frame(8'h07, 1'b1, 1'b1);
    wait_cycles(20);
    check("par_ok_done_count", n_done - b_done, 1);
    check("par_ok_perr_count", n_perr - b_perr, 0);
    check("par_ok_byte", byte_at(b_done), 32'h07);
`endif

    check("strobe_overlap_count", n_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
